// File: rtl/vga_scan_out.sv
// VGA scan-out: raster timing, framebuffer coordinate generation, palette
// lookup and pixel-aligned RGB444/sync outputs with frame pacing signals.
module vga_scan_out #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_pxlX,
  output logic [7:0]  o_pxlY,
  input  logic [3:0]  i_value,
  input  logic        i_palWe,
  input  logic [3:0]  i_palIdx,
  input  logic [11:0] i_palRgb,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frameStart,
  output logic [15:0] o_frameCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [7:0]    X_OUT  = 8'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [7:0]    Y_OUT  = 8'(V_ACTIVE >> SCALE_SHIFT);

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              h_wrap;
  logic              v_wrap;
  logic              active;
  logic              hs_n;
  logic              vs_n;
  logic [RD_LAT-1:0] act_pipe;
  logic [RD_LAT-1:0] hs_pipe;
  logic [RD_LAT-1:0] vs_pipe;
  logic [11:0]       pal [16];
  logic [11:0]       rgb_q;
  logic              hs_q;
  logic              vs_q;
  logic [15:0]       frame_cnt;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (h_wrap) begin
      h <= '0;
      if (v_wrap) begin
        v         <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v <= v + VW'(1);
      end
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    o_pxlX       = (h < H_ACT) ? 8'(h >> SCALE_SHIFT) : X_OUT;
    o_pxlY       = (v < V_ACT) ? 8'(v >> SCALE_SHIFT) : Y_OUT;
    active       = (h < H_ACT) && (v < V_ACT);
    hs_n         = !((h >= HS_BEG) && (h <= HS_END));
    vs_n         = !((v >= VS_BEG) && (v <= VS_END));
    o_frameStart = (h == '0) && (v == '0);
  end

  // Flags travel alongside the color-stage read so they land with i_value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      act_pipe <= RD_LAT'({act_pipe, active});
      hs_pipe  <= RD_LAT'({hs_pipe, hs_n});
      vs_pipe  <= RD_LAT'({vs_pipe, vs_n});
      rgb_q    <= act_pipe[RD_LAT-1] ? pal[i_value] : '0;
      hs_q     <= hs_pipe[RD_LAT-1];
      vs_q     <= vs_pipe[RD_LAT-1];
    end
  end

  // Lookup reads the pre-edge palette, so a same-cycle write is seen next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        pal[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (i_palWe) begin
      pal[i_palIdx] <= i_palRgb;
    end
  end

  assign o_red      = rgb_q[11:8];
  assign o_green    = rgb_q[7:4];
  assign o_blue     = rgb_q[3:0];
  assign o_hsync    = hs_q;
  assign o_vsync    = vs_q;
  assign o_frameCnt = frame_cnt;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: cycle-indexed raster model plus directed literal checks.
// Vertical timing is shortened so several frames fit in a short run.
module tb_vga_scan_out;

  localparam int HA = 640;
  localparam int HFP = 16;
  localparam int HSW = 96;
  localparam int HBP = 48;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 24;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int LAT = 3;

  logic        clk;
  logic        i_rst;
  logic [7:0]  o_pxlX;
  logic [7:0]  o_pxlY;
  logic [3:0]  i_value;
  logic        i_palWe;
  logic [3:0]  i_palIdx;
  logic [11:0] i_palRgb;
  logic [3:0]  o_red;
  logic [3:0]  o_green;
  logic [3:0]  o_blue;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_frameStart;
  logic [15:0] o_frameCnt;

  int tests = 0;
  int fails = 0;
  int sn = 0;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SCALE_SHIFT(2), .RD_LAT(2)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .o_pxlX(o_pxlX), .o_pxlY(o_pxlY),
    .i_value(i_value), .i_palWe(i_palWe), .i_palIdx(i_palIdx), .i_palRgb(i_palRgb),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_frameStart(o_frameStart), .o_frameCnt(o_frameCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hh(input int m);
    return m % HT;
  endfunction

  function automatic int vv(input int m);
    return (m / HT) % VT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Color stage: returns the low nibble of the column two cycles later, 0 off-screen.
  initial begin
    logic [7:0] qx[$];
    logic [7:0] qy[$];
    logic [7:0] x;
    logic [7:0] y;
    i_value = '0;
    forever begin
      @(negedge clk);
      qx.push_back(o_pxlX);
      qy.push_back(o_pxlY);
      if (qx.size() > 2) begin
        x = qx.pop_front();
        y = qy.pop_front();
        i_value = (x < 8'(HA / 4) && y < 8'(VA / 4)) ? x[3:0] : 4'h0;
      end
    end
  end

  // Raster model: cycle n since reset release determines every output.
  initial begin
    int n;
    int m;
    int h;
    int v;
    bit started;
    logic [11:0] exp_rgb;
    logic [11:0] pal_m [16];
    n = 0;
    started = 1'b0;
    exp_rgb = '0;
    forever begin
      @(negedge clk);
      if (started) begin
        h = hh(n);
        v = vv(n);
        m = n - LAT;
        chk($sformatf("pxlX@%0d", n), o_pxlX, (h < HA) ? h / 4 : HA / 4);
        chk($sformatf("pxlY@%0d", n), o_pxlY, (v < VA) ? v / 4 : VA / 4);
        chk($sformatf("fstart@%0d", n), o_frameStart, (n % FR) == 0);
        chk($sformatf("fcnt@%0d", n), o_frameCnt, (n / FR) % 65536);
        chk($sformatf("hsync@%0d", n), o_hsync,
            (m < 0) ? 1 : !(hh(m) >= HA + HFP && hh(m) < HA + HFP + HSW));
        chk($sformatf("vsync@%0d", n), o_vsync,
            (m < 0) ? 1 : !(vv(m) >= VA + VFP && vv(m) < VA + VFP + VSW));
        chk($sformatf("rgb@%0d", n), {o_red, o_green, o_blue}, exp_rgb);
      end
      if (i_rst) begin
        started = 1'b1;
        n = 0;
        exp_rgb = '0;
        for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
      end else if (started) begin
        n++;
        m = n - LAT;
        if (m >= 0 && hh(m) < HA && vv(m) < VA) exp_rgb = pal_m[(hh(m) / 4) % 16];
        else exp_rgb = '0;
        if (i_palWe) pal_m[i_palIdx] = i_palRgb;
      end
    end
  end

  task automatic adv_to(input int k);
    while (sn < k) begin
      @(posedge clk);
      #1;
      sn++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_palWe = 1'b0;
    i_palIdx = '0;
    i_palRgb = '0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    sn = 0;

    chk("lit_reset_pxlX", o_pxlX, 0);
    chk("lit_reset_pxlY", o_pxlY, 0);
    chk("lit_reset_fstart", o_frameStart, 1);
    chk("lit_reset_hsync", o_hsync, 1);
    chk("lit_reset_vsync", o_vsync, 1);
    chk("lit_reset_rgb", {o_red, o_green, o_blue}, 12'h000);
    chk("lit_reset_fcnt", o_frameCnt, 0);
    adv_to(4);     chk("lit_pxlX_h4", o_pxlX, 1);
    adv_to(7);     chk("lit_rgb_h4", {o_red, o_green, o_blue}, 12'h111);
    adv_to(639);   chk("lit_pxlX_h639", o_pxlX, 159);
    adv_to(640);   chk("lit_pxlX_h640", o_pxlX, 160);
    adv_to(658);   chk("lit_hsync_658", o_hsync, 1);
    adv_to(659);   chk("lit_hsync_659", o_hsync, 0);
    adv_to(754);   chk("lit_hsync_754", o_hsync, 0);
    adv_to(755);   chk("lit_hsync_755", o_hsync, 1);
    adv_to(800);   chk("lit_fstart_800", o_frameStart, 0);
    adv_to(3200);  chk("lit_pxlY_v4", o_pxlY, 1);
    adv_to(19200); chk("lit_pxlY_v24", o_pxlY, 6);
    adv_to(19223); chk("lit_rgb_v24", {o_red, o_green, o_blue}, 12'h000);
    adv_to(20802); chk("lit_vsync_20802", o_vsync, 1);
    adv_to(20803); chk("lit_vsync_20803", o_vsync, 0);
    adv_to(22402); chk("lit_vsync_22402", o_vsync, 0);
    adv_to(22403); chk("lit_vsync_22403", o_vsync, 1);
    adv_to(23999); chk("lit_fcnt_23999", o_frameCnt, 0);
    adv_to(24000); chk("lit_fcnt_24000", o_frameCnt, 1);
    chk("lit_fstart_24000", o_frameStart, 1);

    // Pixel (h=20, v=2) of frame 1 reads index 5 during cycle +2; write entry 5 then.
    adv_to(25622);
    i_palWe = 1'b1;
    i_palIdx = 4'd5;
    i_palRgb = 12'hF00;
    adv_to(25623);
    i_palWe = 1'b0;
    chk("lit_pal_old", {o_red, o_green, o_blue}, 12'h555);
    adv_to(25624); chk("lit_pal_new", {o_red, o_green, o_blue}, 12'hF00);

    // Mid-frame reset at h=300, v=20 of frame 1.
    adv_to(24000 + 20 * HT + 300);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    sn = 0;
    chk("lit_rst_pxlX", o_pxlX, 0);
    chk("lit_rst_pxlY", o_pxlY, 0);
    chk("lit_rst_rgb", {o_red, o_green, o_blue}, 12'h000);
    chk("lit_rst_hsync", o_hsync, 1);
    chk("lit_rst_vsync", o_vsync, 1);
    chk("lit_rst_fcnt", o_frameCnt, 0);
    adv_to(23);    chk("lit_rst_pal5", {o_red, o_green, o_blue}, 12'h555);
    adv_to(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
